// File: rtl/uart_rx_responder_pkg.sv
// Shared types and constants for the memory-mapped UART receiver.
// Register offsets, status bit positions and oversampling constants live here.
package uart_rx_responder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    localparam logic RXDATA_ADDR = 1'b0;
    localparam logic STATUS_ADDR = 1'b1;

    localparam int ST_NOT_EMPTY = 0;
    localparam int ST_FULL      = 1;
    localparam int ST_FRAME_ERR = 2;
    localparam int ST_OVERRUN   = 3;

    localparam int OVERSAMPLE = 16;
    localparam int MID_SAMPLE = 8;

    // Clocks per oversampling tick, floored, never below one.
    function automatic int calc_div(input int clk_freq, input int baud_rate);
        int d;
        d = clk_freq / (baud_rate * OVERSAMPLE);
        return (d < 1) ? 1 : d;
    endfunction

endpackage

// File: rtl/uart_rx_responder_fifo.sv
// Receive FIFO: power-of-two depth, pointers wrap naturally.
// A push while full is accepted only when a pop frees a slot in the same cycle.
module rx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_COUNT);
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (do_pop && !do_push) count <= count - 1'b1;
        end
    end

    // Storage carries no reset; occupancy is tracked solely by count.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/uart_rx_responder.sv
// 8N1 UART receiver with a receive FIFO and a two-register load interface.
// RXDATA loads pop the FIFO; STATUS loads clear the sticky error flags.
module uart_rx_responder
    import uart_rx_responder_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD_RATE  = 115200,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  SerialIn,
    input  logic                  rdEn,
    input  logic                  addr,
    output logic [DATA_WIDTH-1:0] ReadReg,
    output logic                  rx_ready
);

    localparam int DIV   = calc_div(CLK_FREQ, BAUD_RATE);
    localparam int DIV_W = $clog2(DIV + 1);
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV - 1);
    localparam logic [3:0]       LAST_TICK = 4'(OVERSAMPLE - 1);
    localparam logic [3:0]       MID_TICK  = 4'(MID_SAMPLE - 1);

    rx_state_t        state, state_n;
    logic [1:0]       sync_q;
    logic             rx_s;
    logic [DIV_W-1:0] div_cnt;
    logic             tick;
    logic [3:0]       tick_cnt, tick_cnt_n;
    logic [2:0]       bit_idx, bit_idx_n;
    logic [7:0]       shift, shift_n;
    logic             stop_hold, stop_hold_n;
    logic             push;
    logic             frame_err_set;
    logic             frame_err, overrun;
    logic             fifo_full, fifo_empty;
    logic [7:0]       head;
    logic             pop;
    logic             status_clr;

    // Load strobe: rdEn is high for exactly one cycle per load; ReadReg is
    // valid combinationally in that cycle and the side effect (pop or flag
    // clear) takes place at the closing clock edge. There is no back-pressure.
    assign pop        = rdEn && (addr == RXDATA_ADDR);
    assign status_clr = rdEn && (addr == STATUS_ADDR);
    assign rx_s       = sync_q[1];
    assign tick       = (state != IDLE) && (div_cnt == DIV_LAST);
    assign rx_ready   = !fifo_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q    <= 2'b11;
            state     <= IDLE;
            div_cnt   <= '0;
            tick_cnt  <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            stop_hold <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            sync_q    <= {sync_q[0], SerialIn};
            state     <= state_n;
            tick_cnt  <= tick_cnt_n;
            bit_idx   <= bit_idx_n;
            shift     <= shift_n;
            stop_hold <= stop_hold_n;
            if (state == IDLE || div_cnt == DIV_LAST) div_cnt <= '0;
            else                                      div_cnt <= div_cnt + 1'b1;
            // Setting a flag wins over a simultaneous STATUS clear.
            if (frame_err_set)   frame_err <= 1'b1;
            else if (status_clr) frame_err <= 1'b0;
            if (push && fifo_full && !pop) overrun <= 1'b1;
            else if (status_clr)           overrun <= 1'b0;
        end
    end

    always_comb begin
        state_n       = state;
        tick_cnt_n    = tick_cnt;
        bit_idx_n     = bit_idx;
        shift_n       = shift;
        stop_hold_n   = stop_hold;
        push          = 1'b0;
        frame_err_set = 1'b0;
        unique case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_n     = START;
                    tick_cnt_n  = '0;
                    stop_hold_n = 1'b0;
                end
            end
            START: begin
                if (tick) begin
                    if (tick_cnt == MID_TICK) begin
                        tick_cnt_n = '0;
                        bit_idx_n  = '0;
                        state_n    = rx_s ? IDLE : DATA;
                    end else begin
                        tick_cnt_n = tick_cnt + 1'b1;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (tick_cnt == LAST_TICK) begin
                        tick_cnt_n = '0;
                        shift_n    = {rx_s, shift[7:1]};
                        if (bit_idx == 3'd7) state_n = STOP;
                        else                 bit_idx_n = bit_idx + 1'b1;
                    end else begin
                        tick_cnt_n = tick_cnt + 1'b1;
                    end
                end
            end
            STOP: begin
                if (stop_hold) begin
                    // Broken frame: wait for the line to return high.
                    if (rx_s) begin
                        state_n     = IDLE;
                        stop_hold_n = 1'b0;
                    end
                end else if (tick) begin
                    if (tick_cnt == LAST_TICK) begin
                        tick_cnt_n = '0;
                        if (rx_s) begin
                            push    = 1'b1;
                            state_n = IDLE;
                        end else begin
                            frame_err_set = 1'b1;
                            stop_hold_n   = 1'b1;
                        end
                    end else begin
                        tick_cnt_n = tick_cnt + 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    rx_fifo #(
        .WIDTH(8),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (push),
        .pop  (pop),
        .din  (shift),
        .dout (head),
        .full (fifo_full),
        .empty(fifo_empty)
    );

    always_comb begin
        ReadReg = '0;
        if (addr == STATUS_ADDR) begin
            ReadReg[ST_NOT_EMPTY] = !fifo_empty;
            ReadReg[ST_FULL]      = fifo_full;
            ReadReg[ST_FRAME_ERR] = frame_err;
            ReadReg[ST_OVERRUN]   = overrun;
        end else if (!fifo_empty) begin
            ReadReg[7:0] = head;
        end
    end

endmodule

// File: tb/tb_uart_rx_responder.sv
// Directed bench for uart_rx_responder at DIV=2 (32 clocks per bit).
// Inputs change and outputs are sampled around the falling clock edge.
module tb_uart_rx_responder;
    import uart_rx_responder_pkg::*;

    localparam int BIT_CLKS = 32;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        SerialIn = 1'b1;
    logic        rdEn = 1'b0;
    logic        addr = 1'b0;
    logic [31:0] ReadReg;
    logic        rx_ready;

    int pass_cnt  = 0;
    int total_cnt = 0;

    uart_rx_responder #(
        .DATA_WIDTH(32),
        .CLK_FREQ  (3200000),
        .BAUD_RATE (100000),
        .FIFO_DEPTH(8)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .SerialIn(SerialIn),
        .rdEn    (rdEn),
        .addr    (addr),
        .ReadReg (ReadReg),
        .rx_ready(rx_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_lvl);
        SerialIn = 1'b0;
        idle(BIT_CLKS);
        for (int i = 0; i < 8; i++) begin
            SerialIn = b[i];
            idle(BIT_CLKS);
        end
        SerialIn = stop_lvl;
        idle(BIT_CLKS);
        SerialIn = 1'b1;
    endtask

    // One-cycle load; data is sampled 1 time unit after the falling edge.
    task automatic load(input logic a, input logic en, output logic [31:0] data);
        addr = a;
        rdEn = en;
        #1 data = ReadReg;
        @(negedge clk);
        rdEn = 1'b0;
        addr = 1'b0;
    endtask

    task automatic wait_ready(input string tag, input int max_cycles);
        int n;
        n = 0;
        while (!rx_ready && n < max_cycles) begin
            @(negedge clk);
            n++;
        end
        check(tag, {31'b0, rx_ready}, 32'h1);
    endtask

    logic [31:0] rd;

    initial begin
        // Reset state
        idle(3);
        rst = 1'b0;
        idle(2);
        check("reset_rx_ready", {31'b0, rx_ready}, 32'h0);
        load(RXDATA_ADDR, 1'b0, rd);
        check("reset_rxdata", rd, 32'h0);
        load(STATUS_ADDR, 1'b0, rd);
        check("reset_status", rd, 32'h0);
        check("reset_state", 32'(dut.state), 32'(IDLE));

        // 1: single frame 0x55
        send_frame(8'h55, 1'b1);
        wait_ready("t1_ready", 400);
        load(STATUS_ADDR, 1'b0, rd);
        check("t1_status_pre", rd, 32'h1);
        load(RXDATA_ADDR, 1'b1, rd);
        check("t1_data", rd, 32'h55);
        load(STATUS_ADDR, 1'b0, rd);
        check("t1_status_post", rd, 32'h0);
        check("t1_rx_ready_post", {31'b0, rx_ready}, 32'h0);

        // 2: three back-to-back frames, read in order, then empty read
        send_frame(8'hA3, 1'b1);
        send_frame(8'h0F, 1'b1);
        send_frame(8'hFF, 1'b1);
        idle(8);
        load(RXDATA_ADDR, 1'b1, rd);
        check("t2_data0", rd, 32'hA3);
        load(RXDATA_ADDR, 1'b1, rd);
        check("t2_data1", rd, 32'h0F);
        load(RXDATA_ADDR, 1'b1, rd);
        check("t2_data2", rd, 32'hFF);
        load(RXDATA_ADDR, 1'b1, rd);
        check("t2_empty_read", rd, 32'h0);
        load(STATUS_ADDR, 1'b0, rd);
        check("t2_status", rd, 32'h0);

        // 3: 8-clock glitch from idle
        SerialIn = 1'b0;
        idle(8);
        SerialIn = 1'b1;
        idle(BIT_CLKS);
        check("t3_state", 32'(dut.state), 32'(IDLE));
        load(STATUS_ADDR, 1'b0, rd);
        check("t3_status", rd, 32'h0);

        // 4: framing error, cleared by a STATUS load
        send_frame(8'h3C, 1'b0);
        idle(8);
        load(STATUS_ADDR, 1'b0, rd);
        check("t4_status_err", rd, 32'h4);
        load(STATUS_ADDR, 1'b1, rd);
        check("t4_status_clr_read", rd, 32'h4);
        load(STATUS_ADDR, 1'b0, rd);
        check("t4_status_after", rd, 32'h0);
        check("t4_rx_ready", {31'b0, rx_ready}, 32'h0);

        // 5: nine frames into an eight-entry FIFO
        for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b1);
        idle(8);
        load(STATUS_ADDR, 1'b0, rd);
        check("t5_status_overrun", rd, 32'hB);
        load(STATUS_ADDR, 1'b0, rd);
        check("t5_status_no_side_effect", rd, 32'hB);
        for (int i = 1; i <= 8; i++) begin
            load(RXDATA_ADDR, 1'b1, rd);
            check($sformatf("t5_data%0d", i), rd, 32'(i));
        end
        load(RXDATA_ADDR, 1'b1, rd);
        check("t5_dropped", rd, 32'h0);
        load(STATUS_ADDR, 1'b1, rd);
        check("t5_status_drained", rd, 32'h8);
        load(STATUS_ADDR, 1'b0, rd);
        check("t5_status_cleared", rd, 32'h0);

        // 6: reset during data bit 3 of 0x81, then a clean 0x42
        SerialIn = 1'b0;
        idle(BIT_CLKS);
        SerialIn = 1'b1;
        idle(BIT_CLKS);
        SerialIn = 1'b0;
        idle(2 * BIT_CLKS);
        idle(BIT_CLKS / 2);
        rst = 1'b1;
        idle(3);
        SerialIn = 1'b1;
        idle(3);
        rst = 1'b0;
        idle(BIT_CLKS);
        check("t6_state", 32'(dut.state), 32'(IDLE));
        load(STATUS_ADDR, 1'b0, rd);
        check("t6_status_pre", rd, 32'h0);
        send_frame(8'h42, 1'b1);
        wait_ready("t6_ready", 400);
        load(RXDATA_ADDR, 1'b1, rd);
        check("t6_data", rd, 32'h42);
        load(STATUS_ADDR, 1'b0, rd);
        check("t6_status_post", rd, 32'h0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
